// File: rtl/avalon_bus_arbiter.sv
// -----------------------------------------------------------------------------
// avalon_bus_arbiter
//
// Two-master, one-slave Avalon-MM arbiter. The CPU data-access port (master 0)
// and instruction-fetch port (master 1) share the single RAM slave. Transfers
// are serialised one per grant. Each grant is followed by at least one IDLE
// cycle. The non-owning master is always held in waitrequest.
//
// Parameters:
//   ADDR_W  address width
//   DATA_W  data width (byteenable width is DATA_W/8)
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   m0_* / m1_*                Avalon-MM slave-side ports facing the two masters
//                              (address, read, write, writedata, byteenable in;
//                              waitrequest, readdata out)
//   s_*                        Avalon-MM master-side port facing the RAM slave
//   busy                       high while a grant is held
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, ties in IDLE go to the master that was
//                       not granted last. When undefined, master 0 wins ties.
// -----------------------------------------------------------------------------
module avalon_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,

    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,

    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;

    // Master index of the most recent completed transfer. Reset to 1 so that
    // master 0 wins the first tie under round-robin.
    logic   last_grant;
    logic   last_grant_nxt;

    logic   req0;
    logic   req1;
    logic   pick1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Read data is broadcast. Only the owning master in its completion cycle
    // treats it as valid.
    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

    assign busy = (state == GRANT0) || (state == GRANT1);

    // Arbitration decision used when leaving IDLE. pick1 = 1 grants master 1.
    always_comb begin
        pick1 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            pick1 = ~last_grant;
        end else begin
            pick1 = req1 & ~req0;
        end
`else
        pick1 = req1 & ~req0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next-state logic and combinational slave mux. Outside a grant, every
    // slave-facing output is driven to zero and both masters are stalled. A
    // master asserting read and write together is treated as a write.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = pick1 ? GRANT1 : GRANT0;
                end
            end

            GRANT0: begin
                if (req0) begin
                    s_address      = m0_address;
                    s_write        = m0_write;
                    s_read         = m0_read & ~m0_write;
                    s_writedata    = m0_writedata;
                    s_byteenable   = m0_byteenable;
                    m0_waitrequest = s_waitrequest;
                    if (!s_waitrequest) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = 1'b0;
                    end
                end else begin
                    // Request withdrawn mid-grant: release without a strobe.
                    state_nxt = IDLE;
                end
            end

            GRANT1: begin
                if (req1) begin
                    s_address      = m1_address;
                    s_write        = m1_write;
                    s_read         = m1_read & ~m1_write;
                    s_writedata    = m1_writedata;
                    s_byteenable   = m1_byteenable;
                    m1_waitrequest = s_waitrequest;
                    if (!s_waitrequest) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
`timescale 1ns/1ps
module tb_avalon_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] m0_address = '0;
    logic        m0_read = 1'b0;
    logic        m0_write = 1'b0;
    logic [31:0] m0_writedata = '0;
    logic [3:0]  m0_byteenable = '0;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;

    logic [31:0] m1_address = '0;
    logic        m1_read = 1'b0;
    logic        m1_write = 1'b0;
    logic [31:0] m1_writedata = '0;
    logic [3:0]  m1_byteenable = '0;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;

    logic [31:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest = 1'b0;
    logic [31:0] s_readdata;

    logic        busy;

    avalon_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0_address     (m0_address),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_writedata   (m0_writedata),
        .m0_byteenable  (m0_byteenable),
        .m0_waitrequest (m0_waitrequest),
        .m0_readdata    (m0_readdata),
        .m1_address     (m1_address),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_byteenable  (m1_byteenable),
        .m1_waitrequest (m1_waitrequest),
        .m1_readdata    (m1_readdata),
        .s_address      (s_address),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_writedata    (s_writedata),
        .s_byteenable   (s_byteenable),
        .s_waitrequest  (s_waitrequest),
        .s_readdata     (s_readdata),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Slave read data: one boot-ROM word, otherwise address ^ 0x5A5A0000.
    always_comb begin
        if (!s_read)
            s_readdata = '0;
        else if (s_address == 32'hBFC0_0000)
            s_readdata = 32'h2402_0010;
        else
            s_readdata = s_address ^ 32'h5A5A_0000;
    end

    typedef struct packed {
        logic        master;
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } xfer_t;

    xfer_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    function automatic xfer_t mk(input logic m, input logic [31:0] a,
                                 input logic rd, input logic wr,
                                 input logic [31:0] wd, input logic [3:0] be,
                                 input logic [31:0] rdat);
        xfer_t x;
        x.master = m; x.addr = a; x.rd = rd; x.wr = wr;
        x.wdata = wd; x.be = be; x.rdata = rdat;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares every completed transfer (owner waitrequest low) against the queue.
    task automatic monitor();
        xfer_t obs;
        xfer_t ex;
        forever begin
            @(negedge clk);
            if (reset == 1'b0 && (m0_waitrequest == 1'b0 || m1_waitrequest == 1'b0)) begin
                obs.master = (m0_waitrequest != 1'b0);
                obs.addr   = s_address;
                obs.rd     = s_read;
                obs.wr     = s_write;
                obs.wdata  = s_writedata;
                obs.be     = s_byteenable;
                obs.rdata  = obs.master ? m1_readdata : m0_readdata;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL xfer_unexpected: got m=%0d a=%h r=%b w=%b, required no transfer",
                             obs.master, obs.addr, obs.rd, obs.wr);
                end else begin
                    ex = exp_q.pop_front();
                    if (obs !== ex) begin
                        bad++;
                        $display("FAIL xfer: got m=%0d a=%h r=%b w=%b wd=%h be=%h rd=%h required m=%0d a=%h r=%b w=%b wd=%h be=%h rd=%h",
                                 obs.master, obs.addr, obs.rd, obs.wr, obs.wdata, obs.be, obs.rdata,
                                 ex.master, ex.addr, ex.rd, ex.wr, ex.wdata, ex.be, ex.rdata);
                    end
                end
            end
        end
    endtask

    // Waits (bounded) for the given master's completion, then steps past that edge.
    task automatic wait_done(input logic m);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (reset == 1'b0 && (m ? m1_waitrequest : m0_waitrequest) == 1'b0)
                seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: master %0d got no completion, required one within 20 cycles", m);
        end
        tick();
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset held with both masters requesting.
        m0_read = 1'b1; m0_address = 32'h0000_0100; m0_byteenable = 4'hF;
        m1_read = 1'b1; m1_address = 32'h0000_0200; m1_byteenable = 4'hF;
        repeat (2) tick();
        @(negedge clk);
        check("rst_s_read",    {31'b0, s_read}, 32'd0);
        check("rst_s_write",   {31'b0, s_write}, 32'd0);
        check("rst_s_address", s_address, 32'd0);
        check("rst_s_wdata",   s_writedata, 32'd0);
        check("rst_s_be",      {28'b0, s_byteenable}, 32'd0);
        check("rst_m0_wait",   {31'b0, m0_waitrequest}, 32'd1);
        check("rst_m1_wait",   {31'b0, m1_waitrequest}, 32'd1);
        check("rst_busy",      {31'b0, busy}, 32'd0);

        // Release: master 0 granted on the next edge.
        tick();
        reset = 1'b0;
        m1_read = 1'b0; m1_address = '0;
        exp_q.push_back(mk(1'b0, 32'h0000_0100, 1'b1, 1'b0, 32'h0, 4'hF, 32'h5A5A_0100));
        @(negedge clk);
        check("rel_idle_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("rel_grant_busy", {31'b0, busy}, 32'd1);
        check("rel_grant_addr", s_address, 32'h0000_0100);
        tick();
        m0_read = 1'b0; m0_address = '0;
        check("rel_q_empty", exp_q.size(), 32'd0);

        // Single read from master 1, zero-wait slave.
        m1_read = 1'b1; m1_address = 32'hBFC0_0000;
        exp_q.push_back(mk(1'b1, 32'hBFC0_0000, 1'b1, 1'b0, 32'h0, 4'hF, 32'h2402_0010));
        tick();
        @(negedge clk);
        check("rd_s_read",   {31'b0, s_read}, 32'd1);
        check("rd_s_addr",   s_address, 32'hBFC0_0000);
        check("rd_m1_data",  m1_readdata, 32'h2402_0010);
        check("rd_m1_wait",  {31'b0, m1_waitrequest}, 32'd0);
        tick();
        check("rd_idle_busy", {31'b0, busy}, 32'd0);
        m1_read = 1'b0; m1_address = '0;
        check("rd_q_empty", exp_q.size(), 32'd0);

        // Tie, both masters requesting continuously for 4 grants.
        m0_write = 1'b1; m0_address = 32'h0000_2000; m0_writedata = 32'h11; m0_byteenable = 4'h3;
        m1_read  = 1'b1; m1_address = 32'h0000_3000;
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(1'b0, 32'h0000_2000, 1'b0, 1'b1, 32'h11, 4'h3, 32'h0));
            exp_q.push_back(mk(1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0, 4'hF, 32'h5A5A_3000));
        end
`else
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk(1'b0, 32'h0000_2000, 1'b0, 1'b1, 32'h11, 4'h3, 32'h0));
`endif
        repeat (8) tick();
        m0_write = 1'b0; m0_address = '0; m0_writedata = '0; m0_byteenable = 4'hF;
        m1_read = 1'b0; m1_address = '0;
        check("tie_q_empty", exp_q.size(), 32'd0);
        tick();

        // Write with 3 slave wait cycles.
        s_waitrequest = 1'b1;
        m0_write = 1'b1; m0_address = 32'h0000_1000; m0_writedata = 32'h0000_00A0; m0_byteenable = 4'hF;
        exp_q.push_back(mk(1'b0, 32'h0000_1000, 1'b0, 1'b1, 32'h0000_00A0, 4'hF, 32'h0));
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ww_s_write", {31'b0, s_write}, 32'd1);
            check("ww_m0_wait", {31'b0, m0_waitrequest}, {31'b0, (k < 3)});
            check("ww_m1_wait", {31'b0, m1_waitrequest}, 32'd1);
            tick();
            if (k == 2) s_waitrequest = 1'b0;
        end
        check("ww_s_write_end", {31'b0, s_write}, 32'd0);
        m0_write = 1'b0; m0_address = '0; m0_writedata = '0;
        check("ww_q_empty", exp_q.size(), 32'd0);

        // Reset during GRANT1 with slave stalling.
        s_waitrequest = 1'b1;
        m1_read = 1'b1; m1_address = 32'h0000_4000;
        tick();
        @(negedge clk);
        check("rm_s_read_pre", {31'b0, s_read}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rm_s_read_drop", {31'b0, s_read}, 32'd0);
        check("rm_busy_drop",   {31'b0, busy}, 32'd0);
        check("rm_s_addr_drop", s_address, 32'd0);
        tick();
        reset = 1'b0;
        s_waitrequest = 1'b0;
        exp_q.push_back(mk(1'b1, 32'h0000_4000, 1'b1, 1'b0, 32'h0, 4'hF, 32'h5A5A_4000));
        @(negedge clk);
        check("rm_idle_busy", {31'b0, busy}, 32'd0);
        check("rm_idle_m1w",  {31'b0, m1_waitrequest}, 32'd1);
        wait_done(1'b1);
        m1_read = 1'b0; m1_address = '0;
        check("rm_q_empty", exp_q.size(), 32'd0);

        // Dropped request by master 0 while master 1 is pending.
        s_waitrequest = 1'b1;
        m0_read = 1'b1; m0_address = 32'h0000_5000;
        m1_read = 1'b1; m1_address = 32'h0000_6000;
        tick();
        check("dr_grant_busy", {31'b0, busy}, 32'd1);
        m0_read = 1'b0;
        @(negedge clk);
        check("dr_no_strobe", {31'b0, s_read}, 32'd0);
        tick();
        check("dr_idle_busy", {31'b0, busy}, 32'd0);
        s_waitrequest = 1'b0;
        exp_q.push_back(mk(1'b1, 32'h0000_6000, 1'b1, 1'b0, 32'h0, 4'hF, 32'h5A5A_6000));
        tick();
        check("dr_m1_busy", {31'b0, busy}, 32'd1);
        wait_done(1'b1);
        m1_read = 1'b0; m1_address = '0;
        check("dr_q_empty", exp_q.size(), 32'd0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avalon_bus_arbiter.md
# avalon_bus_arbiter

Two-master, one-slave arbiter for the CPU's Avalon memory-mapped bus. Shares the single `RAM` slave between the CPU's data-access port (master 0) and instruction-fetch port (master 1). Serialises their read/write transfers, routes `waitrequest` and `readdata` back to the owning master, and keeps the non-owner stalled. Sits between `top_level_cpu`'s internal ports and the `RAM` bus pins.

## Interface

Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `byteenable` width is `DATA_W/8`

Ports:
- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `m0_address` / `m1_address`  in  ADDR_W  master address
- `m0_read` / `m1_read`  in  1  read request
- `m0_write` / `m1_write`  in  1  write request
- `m0_writedata` / `m1_writedata`  in  DATA_W  write data
- `m0_byteenable` / `m1_byteenable`  in  DATA_W/8  byte lanes
- `m0_waitrequest` / `m1_waitrequest`  out  1  stall to master
- `m0_readdata` / `m1_readdata`  out  DATA_W  read data to master
- `s_address`  out  ADDR_W  to slave
- `s_read`, `s_write`  out  1  to slave
- `s_writedata`  out  DATA_W  to slave
- `s_byteenable`  out  DATA_W/8  to slave
- `s_waitrequest`  in  1  from slave
- `s_readdata`  in  DATA_W  from slave
- `busy`  out  1  high while in a GRANT state

## Operation

- Request of master x: `req_x = mx_read | mx_write`.
- Master asserting both `read` and `write` is treated as a write; `s_read` is forced 0.
- FSM states: IDLE, GRANT0, GRANT1.
  - IDLE: if any `req_x`, pick winner per arbitration policy (see Configuration), go to GRANTx next edge; else stay.
  - GRANTx: slave outputs mux from master x combinationally. `mx_waitrequest = s_waitrequest`. Transfer completes on an edge where `req_x` = 1 and `s_waitrequest` = 0. Go to IDLE on completion.
  - GRANTx with `req_x` = 0 (protocol violation, dropped request): go to IDLE next edge, no slave strobe that cycle.
- One transfer per grant; no bursts; no back-to-back grants without an IDLE cycle.
- Non-granted master: `waitrequest` = 1 at all times. In IDLE both `waitrequest` = 1.
- `s_readdata` is broadcast to both `m0_readdata` and `m1_readdata`. It is valid only to the granted master in its completion cycle.
- Outside a GRANT: `s_read` = `s_write` = 0, `s_address` = 0, `s_writedata` = 0, `s_byteenable` = 0.
- Registers: state (2 bits), `last_grant` (1 bit, updated on every completion).

## Timing

- Reset (asynchronous, immediate): state = IDLE, `last_grant` = 1 (so master 0 wins first under round-robin). All `s_*` outputs 0, both `waitrequest` 1, `busy` 0.
- Reset mid-transfer: strobes drop immediately. The transfer is abandoned, not replayed.
- Latency:
  - Cycle N: request sampled in IDLE.
  - Cycle N+1: GRANT, slave strobe asserted.
  - With zero-wait slave, completion at end of N+1, so the master sees at least 1 wait cycle.
- Each slave wait cycle adds 1 cycle. Minimum issue interval is 2 cycles per transfer.
- Simultaneous requests in IDLE resolve in the same cycle; the loser keeps `waitrequest` = 1 and is granted after the IDLE following the winner's completion.
- Master signals must stay stable while `waitrequest` = 1 (Avalon rule). The arbiter does not latch them.

## Configuration

- `ARB_ROUND_ROBIN_EN` defined: on a tie in IDLE, grant the master not equal to `last_grant`. A lone requester is always granted.
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority, master 0 (data) always wins ties. `last_grant` is still maintained but unused.

## Test plan

- **Reset**: hold `reset` = 1 with both masters requesting → all `s_*` = 0, `m0_waitrequest` = `m1_waitrequest` = 1, `busy` = 0. Release → first grant on the next edge.
- **Single read**: m1 reads 0xBFC00000, slave zero-wait returns 0x24020010 → `s_read` = 1 with `s_address` = 0xBFC00000 in cycle 1. `m1_readdata` = 0x24020010 with `m1_waitrequest` = 0 in that cycle. State is IDLE in cycle 2.
- **Write with slave wait**: m0 writes 0x000000A0 to 0x00001000 with `byteenable` = 0xF, slave holds `s_waitrequest` = 1 for 3 cycles → `s_write` stays 1 for 4 cycles. `m0_waitrequest` falls in the 4th cycle only. `m1` stays stalled throughout.
- **Tie, 4 transfers**: both masters request continuously, zero-wait slave. With `ARB_ROUND_ROBIN_EN`, grant order is 0,1,0,1. Without it, grant order is 0,0,0,0 and m1 stays stalled.
- **Reset mid-transfer**: assert `reset` while in GRANT1 with `s_waitrequest` = 1 → `s_read` drops in the same cycle without a clock edge. After release, m1 is regranted only via IDLE.
- **Dropped request**: m0 granted, then `m0_read` deasserted while `s_waitrequest` = 1 → next edge IDLE, `busy` = 0. A pending m1 request is granted on the following edge.
